alu_issue_stage: RTL
====================

# alu_issue_stage

Two-stage valid/ready pipeline that feeds the `arithmetic_logic_unit` and registers its result. Commands (operands plus select) are accepted from the controller, held in an issue register that drives the ALU, then captured with the ALU flags into a result register for the downstream consumer. Select codes with no defined ALU operation are screened out before they reach the ALU. Sticky carry/overflow status and a delivered-operation counter are kept for software.

## Interface

Parameters:
- WIDTH, 8, operand/result width; must match the ALU instance.
- COUNT_WIDTH, 16, width of op_count.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command this cycle.
- cmd_a, cmd_b  in  WIDTH  operands.
- cmd_select  in  4  ALU operation code.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_select  out  4  select to the ALU.
- alu_out  in  WIDTH  ALU result; combinational from alu_a/alu_b/alu_select.
- alu_negative, alu_zero, alu_carry_out, alu_overflow  in  1 each  ALU flags.
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes the result.
- res_out  out  WIDTH  registered result.
- res_flags  out  4  {N,Z,C,V}, registered.
- res_illegal  out  1  command carried an undefined select.
- clear_stats  in  1  synchronous clear of sticky_flags and op_count.
- sticky_flags  out  2  {C,V}, sticky OR over delivered legal results.
- op_count  out  COUNT_WIDTH  delivered results, saturating.

## Operation

- Legal selects: 0 OR, 1 XOR, 2 AND, 3 rotate, 4 logical right shift, 5 left shift, 8 add, 9 subtract, 10 arithmetic right shift. Codes 6, 7 and 11–15 are illegal.
- Issue register (I) holds a_valid, a, b, select and an illegal bit computed at accept.
- alu_a and alu_b always drive I's operands.
- alu_select drives I's select when the entry is legal and 4'd0 when it is illegal, so the ALU never sees an undefined code.
- Result register (R) holds res_valid, res_out, res_flags and res_illegal.
- Advance rule: r_free = !res_valid || res_ready.
- cmd_ready = !a_valid || r_free, combinational.
- On a cmd_valid && cmd_ready edge, I loads the command. Otherwise, if I advances into R, a_valid clears.
- When a_valid && r_free, R captures {alu_out, N, Z, C, V} from the ALU.
  - If the I entry is illegal, R captures res_out=0, res_flags=0 and res_illegal=1 instead.
- R holds its contents while res_valid && !res_ready.
- Statistics update on each result handshake (res_valid && res_ready):
  - op_count increments and saturates at all-ones.
  - sticky_flags |= {C,V} of the delivered result. Illegal results contribute 0.
- clear_stats: sticky_flags is cleared, then the same-cycle handshake's flags are ORed in (set wins).
  - op_count becomes 1 on a same-cycle handshake, 0 otherwise.
- No command is dropped or duplicated. Ordering is strictly FIFO.

## Timing

- Reset (rst_n low, asynchronous) clears cmd_ready's inputs:
  - a_valid=0, res_valid=0, res_out=0, res_flags=0, res_illegal=0.
  - alu_a=0, alu_b=0, alu_select=0.
  - sticky_flags=0, op_count=0.
  - cmd_ready is therefore 1 during and after reset.
- Reset mid-operation discards all in-flight commands. No result is produced for them.
- Latency: a command accepted at edge k gives res_valid=1 after edge k+1, when R is free.
- Throughput: one command per cycle while res_ready stays high.
- With res_ready held low: R fills, then I fills. cmd_ready goes low after two accepts and stays low until res_ready rises.
- cmd_ready returns high in the same cycle res_ready is asserted; the pipeline shifts on that edge.
- alu_* outputs change only on accept edges and on reset.

## Test plan

- Legal ops, a=0x4B, b=0x04, res_ready=1:
  - select 0 -> res_out 0x4F.
  - select 2 -> res_out 0x00 with Z=1.
  - select 3 -> res_out 0xB4.
  - select 9 -> res_out 0x47.
  - select 10 -> res_out 0x04.
  - Each result appears with res_valid two edges after accept.
- Backpressure: stream 4 commands (selects 8, 1, 4, 5) with res_ready=0. cmd_ready drops after 2 accepts. Raise res_ready; results 0x4F, 0x4F, 0x04, 0xB0 arrive in order with none lost.
- Illegal select 6, then 11, then legal 0 -> two results with res_illegal=1, res_out=0x00, res_flags=0, then 0x4F with res_illegal=0. alu_select never shows 6 or 11.
- Sticky/clear: a=0x7F, b=0x01, select 8 (V=1) -> sticky_flags=01. Assert clear_stats on the same cycle as a handshake with C=1 -> sticky_flags=10 and op_count=1.
- Saturation: COUNT_WIDTH=4, 20 handshakes -> op_count holds 15.
- Reset mid-stream: drop rst_n with both stages full -> res_valid=0, cmd_ready=1 and op_count=0 immediately. After release, the next command gives the correct result at latency 2.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-entry valid/ready pipeline around an external ALU: an issue register drives the ALU
// and a result register captures its output and flags. Sticky C/V and a delivered-op count are kept.
module alu_issue_stage #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [3:0]             cmd_select,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             alu_select,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_negative,
  input  logic                   alu_zero,
  input  logic                   alu_carry_out,
  input  logic                   alu_overflow,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_out,
  output logic [3:0]             res_flags,
  output logic                   res_illegal,
  input  logic                   clear_stats,
  output logic [1:0]             sticky_flags,
  output logic [COUNT_WIDTH-1:0] op_count
);

  logic                   a_valid_reg;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [3:0]             sel_reg;
  logic                   ill_reg;

  logic                   res_valid_reg;
  logic [WIDTH-1:0]       res_out_reg;
  logic [3:0]             res_flags_reg;
  logic                   res_illegal_reg;

  logic [1:0]             sticky_reg;
  logic [1:0]             sticky_next;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;

  logic                   r_free;
  logic                   accept;
  logic                   advance;
  logic                   handshake;
  logic                   cmd_illegal;
  logic [1:0]             delivered_cv;

  function automatic logic is_legal(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: is_legal = 1'b1;
      default:                                                is_legal = 1'b0;
    endcase
  endfunction

  assign r_free      = !res_valid_reg || res_ready;
  assign cmd_ready   = !a_valid_reg || r_free;
  assign accept      = cmd_valid && cmd_ready;
  assign advance     = a_valid_reg && r_free;
  assign handshake   = res_valid_reg && res_ready;
  assign cmd_illegal = !is_legal(cmd_select);

  // Illegal entries present select 0 so the ALU never decodes an undefined code.
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_select = ill_reg ? 4'd0 : sel_reg;

  assign res_valid    = res_valid_reg;
  assign res_out      = res_out_reg;
  assign res_flags    = res_flags_reg;
  assign res_illegal  = res_illegal_reg;
  assign sticky_flags = sticky_reg;
  assign op_count     = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sel_reg     <= 4'd0;
      ill_reg     <= 1'b0;
    end else if (accept) begin
      a_valid_reg <= 1'b1;
      a_reg       <= cmd_a;
      b_reg       <= cmd_b;
      sel_reg     <= cmd_select;
      ill_reg     <= cmd_illegal;
    end else if (advance) begin
      a_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg   <= 1'b0;
      res_out_reg     <= '0;
      res_flags_reg   <= 4'd0;
      res_illegal_reg <= 1'b0;
    end else if (r_free) begin
      res_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        if (ill_reg) begin
          res_out_reg     <= '0;
          res_flags_reg   <= 4'd0;
          res_illegal_reg <= 1'b1;
        end else begin
          res_out_reg     <= alu_out;
          res_flags_reg   <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
          res_illegal_reg <= 1'b0;
        end
      end
    end
  end

  assign delivered_cv = res_illegal_reg ? 2'b00 : res_flags_reg[1:0];

  // A clear coinciding with a handshake keeps that handshake's contribution.
  always_comb begin
    sticky_next = sticky_reg;
    count_next  = count_reg;
    if (clear_stats) begin
      sticky_next = handshake ? delivered_cv : 2'b00;
      count_next  = handshake ? COUNT_WIDTH'(1) : '0;
    end else if (handshake) begin
      sticky_next = sticky_reg | delivered_cv;
      if (count_reg != {COUNT_WIDTH{1'b1}}) begin
        count_next = count_reg + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 2'b00;
      count_reg  <= '0;
    end else begin
      sticky_reg <= sticky_next;
      count_reg  <= count_next;
    end
  end

endmodule
